// File: rtl/main_bus_arbiter.sv
// Main-bus arbiter between the CPU decode pipeline and one external master.
// Registered bus selects, with starvation and burst limits that bound each side's latency.
module main_bus_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cpu_assert,
    input  logic [3:0] cpu_load,
    input  logic       ext_req,
    input  logic [3:0] ext_assert,
    input  logic [3:0] ext_load,
    output logic [3:0] MainAssert,
    output logic [3:0] MainLoad,
    output logic       ext_gnt,
    output logic       pipe_stall,
    output logic       ext_owner
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [3:0] BURST_MAX  = 4'(MAX_BURST);

    if (DATA_WIDTH < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15 ||
        MAX_BURST < 1 || MAX_BURST > 15) begin : g_param_check
        $error("main_bus_arbiter: parameter out of range");
    end

    typedef enum logic {
        CPU_OWN = 1'b0,
        EXT_OWN = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic [3:0] assert_nxt, load_nxt;
    logic       cpu_busreq;
    logic       grant_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CPU_OWN;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            MainAssert <= '0;
            MainLoad   <= '0;
            ext_gnt    <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
            MainAssert <= assert_nxt;
            MainLoad   <= load_nxt;
            ext_gnt    <= grant_ext;
        end
    end

    always_comb begin
        cpu_busreq = (cpu_assert != 4'd0) || (cpu_load != 4'd0);
        grant_ext  = 1'b0;
        state_nxt  = CPU_OWN;
        starve_nxt = '0;
        burst_nxt  = '0;
        assert_nxt = cpu_assert;
        load_nxt   = cpu_load;

        if (state == CPU_OWN)
            grant_ext = ext_req && (!cpu_busreq || starve_cnt == STARVE_MAX);
        else
            grant_ext = ext_req && (burst_cnt < BURST_MAX);

        if (grant_ext) begin
            state_nxt  = EXT_OWN;
            assert_nxt = ext_assert;
            load_nxt   = ext_load;
            burst_nxt  = (state == EXT_OWN) ? burst_cnt + 4'd1 : 4'd1;
        end else if (ext_req && state == CPU_OWN) begin
            // Leaving EXT_OWN on an exhausted burst restarts the wait from zero.
            starve_nxt = (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 4'd1;
        end
    end

    assign pipe_stall = grant_ext && cpu_busreq && !rst;
    assign ext_owner  = (state == EXT_OWN);

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Directed bench for main_bus_arbiter with STARVE_LIMIT=3, MAX_BURST=2.
module tb_main_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cpu_assert, cpu_load, ext_assert, ext_load;
    logic       ext_req;
    logic [3:0] MainAssert, MainLoad;
    logic       ext_gnt, pipe_stall, ext_owner;

    int nvec = 0;
    int nerr = 0;

    main_bus_arbiter #(.DATA_WIDTH(16), .STARVE_LIMIT(3), .MAX_BURST(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_assert(cpu_assert), .cpu_load(cpu_load),
        .ext_req(ext_req), .ext_assert(ext_assert), .ext_load(ext_load),
        .MainAssert(MainAssert), .MainLoad(MainLoad),
        .ext_gnt(ext_gnt), .pipe_stall(pipe_stall), .ext_owner(ext_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge; inputs are then driven for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs after changing inputs, then check stall.
    task automatic chk_stall(input string tag, input int exp);
        #1;
        chk(tag, int'(pipe_stall), exp);
    endtask

    initial begin
        int bg[6];
        int gexp;
        rst = 1'b1; cpu_assert = 0; cpu_load = 0;
        ext_req = 0; ext_assert = 0; ext_load = 0;
        tick();
        tick();
        chk("rst_assert", MainAssert, 0);
        chk("rst_gnt", ext_gnt, 0);
        chk("rst_owner", ext_owner, 0);

        // CPU idle handoff
        rst = 0; ext_req = 1; ext_assert = 3; ext_load = 6;
        chk_stall("idle_stall", 0);
        tick();
        chk("idle_assert", MainAssert, 3);
        chk("idle_load", MainLoad, 6);
        chk("idle_gnt", ext_gnt, 1);
        chk("idle_owner", ext_owner, 1);

        // Reset mid-burst (burst_cnt=1), with a busy CPU so a live grant would stall
        rst = 1; cpu_assert = 5;
        chk_stall("rst_stall_forced", 0);
        tick();
        chk("rstb_assert", MainAssert, 0);
        chk("rstb_load", MainLoad, 0);
        chk("rstb_gnt", ext_gnt, 0);
        chk("rstb_owner", ext_owner, 0);
        rst = 0; ext_req = 0;
        tick();
        chk("post_rst_assert", MainAssert, 5);
        chk("post_rst_gnt", ext_gnt, 0);

        // Starvation preempt: cycle 0..5
        cpu_assert = 8; cpu_load = 2; ext_req = 1; ext_assert = 10; ext_load = 11;
        chk_stall("starve_c0_stall", 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("starve_c%0d_assert", c), MainAssert, 8);
            chk($sformatf("starve_c%0d_gnt", c), ext_gnt, 0);
            chk_stall($sformatf("starve_c%0d_stall", c), (c == 3) ? 1 : 0);
        end
        tick();
        chk("starve_c4_gnt", ext_gnt, 1);
        chk("starve_c4_assert", MainAssert, 10);
        chk("starve_c4_load", MainLoad, 11);
        ext_req = 0;
        chk_stall("starve_c4_stall", 0);
        tick();
        chk("starve_c5_assert", MainAssert, 8);
        chk("starve_c5_load", MainLoad, 2);
        chk("starve_c5_gnt", ext_gnt, 0);

        // Burst limit: CPU busy, ext_req held from cycle 5
        ext_req = 1;
        // cycles 5..15: expected visible grant and stall this cycle
        for (int c = 5; c <= 15; c++) begin
            if (c > 5) tick();
            gexp = (c == 9 || c == 10 || c == 15) ? 1 : 0;
            chk($sformatf("burst_c%0d_gnt", c), ext_gnt, gexp);
            chk($sformatf("burst_c%0d_owner", c), ext_owner, gexp);
            chk($sformatf("burst_c%0d_assert", c), MainAssert, gexp ? 10 : 8);
            if (c == 15) ext_req = 0;
            chk_stall($sformatf("burst_c%0d_stall", c), (c == 8 || c == 9 || c == 14) ? 1 : 0);
        end

        // Request withdrawn after 2 cycles, then re-raised: cycles 16..23
        for (int c = 16; c <= 23; c++) begin
            tick();
            ext_req = (c == 16 || c == 17 || c >= 19) ? 1'b1 : 1'b0;
            chk($sformatf("wd_c%0d_gnt", c), ext_gnt, (c == 23) ? 1 : 0);
            if (c == 23) ext_req = 0;
            chk_stall($sformatf("wd_c%0d_stall", c), (c == 22) ? 1 : 0);
        end

        // Burst exhaustion with idle CPU
        tick();
        cpu_assert = 0; cpu_load = 0; ext_req = 1;
        chk("ex_start_gnt", ext_gnt, 0);
        bg = '{1, 1, 0, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            chk_stall($sformatf("ex_%0d_stall", i), 0);
            tick();
            chk($sformatf("ex_%0d_gnt", i), ext_gnt, bg[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
